// File: rtl/conv_frame_ctrl.sv
// Frame controller for a 3x3 convolution front end: streams one frame of pixels
// from memory into a line buffer and counts the windows that come back.
module conv_frame_ctrl #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int DRAIN_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [DATA_BITS-1:0] pix_out,
  output logic                 pix_valid,
  output logic                 buf_rst_n,
  input  logic                 win_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          win_count
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [15:0] EXPECTED = 16'((WIDTH - 2) * (HEIGHT - 2));
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr;
  logic [DW-1:0]        drain_cnt;
  logic [1:0]           vld_pipe;
  logic                 accept, full, drain_to;

  assign accept    = (state == IDLE) && start;
  assign full      = (win_count == EXPECTED);
  assign drain_to  = (state == DRAIN) && !full && (drain_cnt == DRAIN_LAST);
  assign mem_addr  = addr;
  assign pix_valid = vld_pipe[1];

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        busy      = 1'b1;
        mem_rd_en = !stall;
        if (!stall && addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (full || drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      pix_out   <= '0;
      win_count <= '0;
      err       <= 1'b0;
      buf_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Clearing the line buffer on the frame's first FETCH cycle is safe: the
      // first pixel only reaches it two cycles later.
      buf_rst_n <= !accept;
      vld_pipe  <= {vld_pipe[0], mem_rd_en};
      if (vld_pipe[0]) pix_out <= mem_rdata;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      if (accept) begin
        addr      <= '0;
        win_count <= '0;
        err       <= 1'b0;
      end else begin
        if (mem_rd_en) addr <= addr + ADDR_BITS'(1);
        if (busy && win_valid) begin
          if (full) err <= 1'b1;
          else      win_count <= win_count + 16'd1;
        end
        if (drain_to) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on a 4x4 frame with a pixel memory and a
// minimal 3x3 line buffer window model attached.
module tb_conv_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata = 8'h0;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        buf_rst_n;
  logic        win_valid;
  logic        busy, done, err;
  logic [15:0] win_count;

  int vec = 0;
  int miss = 0;

  conv_frame_ctrl #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(8), .ADDR_BITS(10), .DRAIN_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .pix_valid(pix_valid), .buf_rst_n(buf_rst_n),
    .win_valid(win_valid), .busy(busy), .done(done), .err(err), .win_count(win_count)
  );

  always #5 clk = ~clk;

  // Pixel memory: data = address + 0x30, one cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0] + 8'h30;

  // Line buffer model: a window is ready once row>=2 and col>=2 of the 4x4 frame.
  logic [2:0] lb_col = 3'd0, lb_row = 3'd0;
  logic       lb_wv = 1'b0;
  logic       win_block = 1'b0, win_force = 1'b0;
  always @(posedge clk) begin
    if (!buf_rst_n) begin
      lb_col <= 3'd0; lb_row <= 3'd0; lb_wv <= 1'b0;
    end else begin
      lb_wv <= pix_valid && lb_row >= 3'd2 && lb_col >= 3'd2;
      if (pix_valid) begin
        if (lb_col == 3'd3) begin lb_col <= 3'd0; lb_row <= lb_row + 3'd1; end
        else lb_col <= lb_col + 3'd1;
      end
    end
  end
  assign win_valid = (lb_wv && !win_block) || win_force;

  // Monitor: log reads, pixels, done pulses and buffer clears with cycle stamps.
  int cyc = 0;
  int rd_addr_q[$], rd_cyc_q[$], pix_q[$], pix_cyc_q[$];
  int done_n = 0, done_cyc = 0, lo_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_addr)); rd_cyc_q.push_back(cyc); end
    if (pix_valid) begin pix_q.push_back(int'(pix_out)); pix_cyc_q.push_back(cyc); end
    if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (!buf_rst_n) lo_n <= lo_n + 1;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if ({busy, done, err, mem_rd_en, pix_valid, buf_rst_n} !== 6'b0) begin
      miss++; $display("FAIL reset_flags got %b want 000000", {busy, done, err, mem_rd_en, pix_valid, buf_rst_n}); end
    vec++; if (win_count !== 16'd0 || pix_out !== 8'd0 || mem_addr !== 10'd0) begin
      miss++; $display("FAIL reset_values win_count=%0d pix_out=%0d mem_addr=%0d want 0", win_count, pix_out, mem_addr); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vec++; if (buf_rst_n !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL reset_release buf_rst_n=%b busy=%b want 1 0", buf_rst_n, busy); end
  endtask

  task automatic test_basic();
    bit ok;
    int br = rd_addr_q.size(), bp = pix_q.size(), d0 = done_n, l0 = lo_n;
    pulse_start();
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    vec++; if (!ok) begin miss++; $display("FAIL basic_timeout no done within 100 cycles"); end
    vec++; if (rd_addr_q.size() - br !== 16) begin
      miss++; $display("FAIL basic_reads got %0d want 16", rd_addr_q.size() - br); end
    for (int i = 0; i < 16 && br + i < rd_addr_q.size(); i++) begin
      vec++; if (rd_addr_q[br+i] !== i || rd_cyc_q[br+i] !== rd_cyc_q[br] + i) begin
        miss++; $display("FAIL basic_addr[%0d] got %0d at +%0d want %0d at +%0d", i, rd_addr_q[br+i], rd_cyc_q[br+i] - rd_cyc_q[br], i, i); end
    end
    for (int i = 0; i < 16 && bp + i < pix_q.size(); i++) begin
      vec++; if (pix_q[bp+i] !== i + 'h30) begin
        miss++; $display("FAIL basic_pix[%0d] got %0h want %0h", i, pix_q[bp+i], i + 'h30); end
    end
    vec++; if (win_count !== 16'd4 || err !== 1'b0) begin
      miss++; $display("FAIL basic_result win_count=%0d err=%b want 4 0", win_count, err); end
    vec++; if (done_n - d0 !== 1 || lo_n - l0 !== 1 || busy !== 1'b0) begin
      miss++; $display("FAIL basic_pulses done=%0d bufclr=%0d busy=%b want 1 1 0", done_n - d0, lo_n - l0, busy); end
  endtask

  task automatic test_stall();
    bit ok;
    int br = rd_addr_q.size(), bp = pix_q.size();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 10'd5) break;
    end
    @(posedge clk); #1 stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++; if (mem_addr !== 10'd6 || mem_rd_en !== 1'b0) begin
        miss++; $display("FAIL stall_hold[%0d] addr=%0d rd_en=%b want 6 0", k, mem_addr, mem_rd_en); end
    end
    @(posedge clk); #1 stall = 1'b0;
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    vec++; if (!ok) begin miss++; $display("FAIL stall_timeout no done within 100 cycles"); end
    vec++; if (pix_q.size() - bp !== 16 || rd_addr_q.size() - br !== 16) begin
      miss++; $display("FAIL stall_counts pix=%0d reads=%0d want 16 16", pix_q.size() - bp, rd_addr_q.size() - br); end
    for (int i = 0; i < 16 && bp + i < pix_q.size(); i++) begin
      vec++; if (pix_q[bp+i] !== i + 'h30) begin
        miss++; $display("FAIL stall_pix[%0d] got %0h want %0h", i, pix_q[bp+i], i + 'h30); end
    end
    if (pix_q.size() - bp >= 7) begin
      vec++; if (pix_cyc_q[bp+6] - pix_cyc_q[bp+5] !== 4) begin
        miss++; $display("FAIL stall_gap got %0d want 4", pix_cyc_q[bp+6] - pix_cyc_q[bp+5]); end
    end
    vec++; if (win_count !== 16'd4 || err !== 1'b0) begin
      miss++; $display("FAIL stall_result win_count=%0d err=%b want 4 0", win_count, err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      int l0 = lo_n, bp = pix_q.size();
      pulse_start();
      wait_done(100, ok);
      vec++; if (!ok) begin miss++; $display("FAIL b2b_timeout frame %0d", f); end
      vec++; if (lo_n - l0 !== 1) begin
        miss++; $display("FAIL b2b_bufclr frame %0d got %0d want 1", f, lo_n - l0); end
      vec++; if (win_count !== 16'd4 || err !== 1'b0 || pix_q.size() - bp !== 16) begin
        miss++; $display("FAIL b2b_result frame %0d win_count=%0d err=%b pix=%0d want 4 0 16", f, win_count, err, pix_q.size() - bp); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_windows();
    bit ok;
    int br = rd_addr_q.size(), d0 = done_n;
    win_block = 1'b1;
    pulse_start();
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    win_block = 1'b0;
    vec++; if (!ok) begin miss++; $display("FAIL nowin_timeout no done within 100 cycles"); end
    if (rd_addr_q.size() - br == 16) begin
      vec++; if (done_cyc - rd_cyc_q[br+15] !== 9) begin
        miss++; $display("FAIL nowin_drain done at +%0d want +9", done_cyc - rd_cyc_q[br+15]); end
    end
    vec++; if (err !== 1'b1 || win_count !== 16'd0 || done_n - d0 !== 1) begin
      miss++; $display("FAIL nowin_result err=%b win_count=%0d done=%0d want 1 0 1", err, win_count, done_n - d0); end
  endtask

  task automatic test_overflow();
    bit ok;
    pulse_start();
    win_force = 1'b1;
    repeat (6) @(posedge clk);
    #1 win_force = 1'b0;
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    vec++; if (!ok) begin miss++; $display("FAIL ovf_timeout no done within 100 cycles"); end
    vec++; if (win_count !== 16'd4 || err !== 1'b1) begin
      miss++; $display("FAIL ovf_result win_count=%0d err=%b want 4 1", win_count, err); end
    @(posedge clk); #1 win_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 win_force = 1'b0;
    vec++; if (win_count !== 16'd4 || err !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL idle_winvalid win_count=%0d err=%b busy=%b want 4 1 0", win_count, err, busy); end
  endtask

  task automatic test_reset_midframe();
    int br = rd_addr_q.size(), d0 = done_n;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 10'd7) break;
    end
    vec++; if (mem_addr !== 10'd7) begin
      miss++; $display("FAIL midrst_reach addr=%0d want 7", mem_addr); end
    for (int i = 0; br + i < rd_addr_q.size(); i++) begin
      vec++; if (rd_addr_q[br+i] !== i) begin
        miss++; $display("FAIL midrst_restart read %0d got addr %0d want %0d", i, rd_addr_q[br+i], i); end
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    vec++; if ({busy, done, err, mem_rd_en, pix_valid, buf_rst_n} !== 6'b0) begin
      miss++; $display("FAIL midrst_flags got %b want 000000", {busy, done, err, mem_rd_en, pix_valid, buf_rst_n}); end
    vec++; if (win_count !== 16'd0 || pix_out !== 8'd0 || mem_addr !== 10'd0) begin
      miss++; $display("FAIL midrst_values win_count=%0d pix_out=%0d mem_addr=%0d want 0", win_count, pix_out, mem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    vec++; if (buf_rst_n !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL midrst_release buf_rst_n=%b busy=%b want 1 0", buf_rst_n, busy); end
    repeat (20) @(negedge clk);
    vec++; if (done_n - d0 !== 0 || mem_rd_en !== 1'b0) begin
      miss++; $display("FAIL midrst_nodone done=%0d rd_en=%b want 0 0", done_n - d0, mem_rd_en); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_no_windows();
    test_overflow();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
